// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
// Stream bundle between a word-wide producer and the lane-wide serialiser.
//
// Parameters
//   WORD_W  input word width (integer multiple of LANE_W)
//   LANE_W  output lane width
//
// Signals
//   in_valid      producer offers a word
//   in_ready      serialiser can accept a word this cycle
//   in_data       word to serialise                      [WORD_W]
//   in_msb_first  1: most-significant lane first; 0: least-significant first
//   in_len        lanes to emit (0 or >N means N)         [LEN_W]
//   out_valid     out_data holds a valid lane
//   out_ready     sink accepts the current lane
//   out_data      current lane                            [LANE_W]
//   out_idx       beat index within the word, 0-based     [LEN_W]
//   out_last      current lane is the final lane of the word
//   busy          a word is held (mirrors out_valid)
//
// Modports
//   master  producer/sink side (drives in_*, out_ready)
//   slave   serialiser side   (drives in_ready, out_*, busy)
// -----------------------------------------------------------------------------
interface word_serializer_if #(
  parameter int WORD_W = 32,
  parameter int LANE_W = 8
);
  localparam int N     = WORD_W / LANE_W;
  localparam int LEN_W = $clog2(N + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_msb_first;
  logic [LEN_W-1:0]  in_len;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [LEN_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
    output in_msb_first,
    output in_len,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_msb_first,
    input  in_len,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    output busy
  );
endinterface

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Breaks a WORD_W word into N = WORD_W/LANE_W lanes and emits them one per
// cycle on a valid/ready stream. Lane order (MSB-first or LSB-first) and the
// number of lanes to emit are captured with the word and stay fixed until its
// last lane has been accepted. A new word can be accepted on the same edge
// that retires the last lane of the current one, so back-to-back words flow
// with no idle beat in between.
//
// Parameters
//   WORD_W  input word width, integer multiple of LANE_W (default 32)
//   LANE_W  output lane width (default 8)
//
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset; drops any held word
//   bus    word_serializer_if.slave stream bundle (see interface header)
//
// All stream outputs come straight from flops; the only combinational path
// from an input to an output is out_ready -> in_ready.
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int WORD_W = 32,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  word_serializer_if.slave bus
);

  localparam int N     = WORD_W / LANE_W;
  localparam int LEN_W = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Lane extraction. Each candidate lane uses a constant slice, so this maps
  // to a plain N:1 mux keyed by the beat index.
  // ---------------------------------------------------------------------------
  function automatic logic [LANE_W-1:0] lane_sel(
    input logic [WORD_W-1:0] word,
    input logic              msb_first,
    input logic [LEN_W-1:0]  idx
  );
    logic [LANE_W-1:0] lane;
    lane = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == LEN_W'(k)) begin
        if (msb_first) begin
          lane = word[WORD_W-1-k*LANE_W -: LANE_W];
        end else begin
          lane = word[k*LANE_W +: LANE_W];
        end
      end
    end
    return lane;
  endfunction

  // Held word context
  state_t            state_r;
  logic [WORD_W-1:0] word_r;
  logic              msb_first_r;
  logic [LEN_W-1:0]  len_last_r;   // index of the final beat, L-1

  // Registered stream outputs
  logic [LANE_W-1:0] out_data_r;
  logic [LEN_W-1:0]  out_idx_r;
  logic              out_last_r;

  // Combinational helpers
  logic              in_ready_s;
  logic              accept_s;
  logic [LEN_W-1:0]  eff_last_s;
  logic [LANE_W-1:0] first_lane_s;
  logic [LEN_W-1:0]  idx_next_s;

  // Space for a new word: nothing held, or the held word's last lane is
  // leaving on this edge. Deliberately independent of in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if (out_last_r && bus.out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  // Effective last-beat index of the offered word; out-of-range lengths
  // (0 or above N) fall back to a full word.
  always_comb begin
    eff_last_s = LEN_W'(N - 1);
    if ((bus.in_len == '0) || (bus.in_len > LEN_W'(N))) begin
      eff_last_s = LEN_W'(N - 1);
    end else begin
      eff_last_s = bus.in_len - LEN_W'(1);
    end
  end

  assign first_lane_s = lane_sel(bus.in_data, bus.in_msb_first, '0);
  assign idx_next_s   = out_idx_r + LEN_W'(1);

  // Serialiser FSM: word capture, beat advance, end-of-word handover.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      word_r      <= '0;
      msb_first_r <= 1'b0;
      len_last_r  <= '0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= SEND;
            word_r      <= bus.in_data;
            msb_first_r <= bus.in_msb_first;
            len_last_r  <= eff_last_s;
            out_data_r  <= first_lane_s;
            out_idx_r   <= '0;
            out_last_r  <= (eff_last_s == '0);
          end else begin
            // out_data keeps its last value while idle
            state_r    <= IDLE;
            out_idx_r  <= '0;
            out_last_r <= 1'b0;
          end
        end

        SEND: begin
          if (!bus.out_ready) begin
            // Backpressure: hold the presented lane unchanged
            state_r <= SEND;
          end else if (!out_last_r) begin
            out_idx_r  <= idx_next_s;
            out_data_r <= lane_sel(word_r, msb_first_r, idx_next_s);
            out_last_r <= (idx_next_s == len_last_r);
          end else if (accept_s) begin
            // Last lane retires while the next word is captured: no bubble
            state_r     <= SEND;
            word_r      <= bus.in_data;
            msb_first_r <= bus.in_msb_first;
            len_last_r  <= eff_last_s;
            out_data_r  <= first_lane_s;
            out_idx_r   <= '0;
            out_last_r  <= (eff_last_s == '0);
          end else begin
            state_r    <= IDLE;
            out_idx_r  <= '0;
            out_last_r <= 1'b0;
          end
        end

        default: begin
          state_r    <= IDLE;
          out_idx_r  <= '0;
          out_last_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == SEND);
  assign bus.busy      = (state_r == SEND);
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Directed bench for word_serializer at WORD_W=32 / LANE_W=8. Inputs change
// 1 ns after each rising edge; outputs are checked there too, away from the
// edge. Every expected value below is written out by hand.
// -----------------------------------------------------------------------------
module tb_word_serializer;
  localparam int WORD_W = 32;
  localparam int LANE_W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  word_serializer_if #(.WORD_W(WORD_W), .LANE_W(LANE_W)) bus ();

  word_serializer #(.WORD_W(WORD_W), .LANE_W(LANE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one presented beat, then let it go (or hold it if out_ready=0).
  task automatic beat(input string tag, input logic [7:0] d, input logic [2:0] i, input logic l);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".idx"},   32'(bus.out_idx),   32'(i));
    chk({tag, ".last"},  32'(bus.out_last),  32'(l));
    chk({tag, ".busy"},  32'(bus.busy),      32'd1);
    tick();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"},    32'(bus.out_valid), 32'd0);
    chk({tag, ".idx"},      32'(bus.out_idx),   32'd0);
    chk({tag, ".last"},     32'(bus.out_last),  32'd0);
    chk({tag, ".busy"},     32'(bus.busy),      32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  // Offer one word for a single edge; the block must be ready for it.
  task automatic send(input logic [31:0] w, input logic msb, input logic [2:0] len);
    bus.in_valid     = 1'b1;
    bus.in_data      = w;
    bus.in_msb_first = msb;
    bus.in_len       = len;
    #1;
    chk("send.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = 32'h0;
    bus.in_msb_first = 1'b0;
    bus.in_len       = 3'd0;
    bus.out_ready    = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.data",  32'(bus.out_data),  32'd0);
    chk("rst.idx",   32'(bus.out_idx),   32'd0);
    chk("rst.last",  32'(bus.out_last),  32'd0);
    chk("rst.busy",  32'(bus.busy),      32'd0);
    reset = 1'b0;
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // MSB-first, full length
    send(32'h12345678, 1'b1, 3'd4);
    chk("msb.b0.in_ready", 32'(bus.in_ready), 32'd0);
    beat("msb.b0", 8'h12, 3'd0, 1'b0);
    beat("msb.b1", 8'h34, 3'd1, 1'b0);
    beat("msb.b2", 8'h56, 3'd2, 1'b0);
    chk("msb.b3.in_ready", 32'(bus.in_ready), 32'd1);
    beat("msb.b3", 8'h78, 3'd3, 1'b1);
    idle_chk("msb.end");

    // LSB-first, full length
    send(32'h12345678, 1'b0, 3'd4);
    beat("lsb.b0", 8'h78, 3'd0, 1'b0);
    beat("lsb.b1", 8'h56, 3'd1, 1'b0);
    beat("lsb.b2", 8'h34, 3'd2, 1'b0);
    beat("lsb.b3", 8'h12, 3'd3, 1'b1);
    idle_chk("lsb.end");

    // Partial word, len=2
    send(32'h12345678, 1'b1, 3'd2);
    beat("len2.b0", 8'h12, 3'd0, 1'b0);
    beat("len2.b1", 8'h34, 3'd1, 1'b1);
    idle_chk("len2.end");

    // len=0 means a full word
    send(32'h12345678, 1'b1, 3'd0);
    beat("len0.b0", 8'h12, 3'd0, 1'b0);
    beat("len0.b1", 8'h34, 3'd1, 1'b0);
    beat("len0.b2", 8'h56, 3'd2, 1'b0);
    beat("len0.b3", 8'h78, 3'd3, 1'b1);
    idle_chk("len0.end");

    // len=5 (>N) also means a full word
    send(32'h9ABCDEF0, 1'b0, 3'd5);
    beat("len5.b0", 8'hF0, 3'd0, 1'b0);
    beat("len5.b1", 8'hDE, 3'd1, 1'b0);
    beat("len5.b2", 8'hBC, 3'd2, 1'b0);
    beat("len5.b3", 8'h9A, 3'd3, 1'b1);
    idle_chk("len5.end");

    // len=1: single beat, last immediately
    send(32'h12345678, 1'b0, 3'd1);
    beat("len1.b0", 8'h78, 3'd0, 1'b1);
    idle_chk("len1.end");

    // Backpressure for 3 cycles on beat 1
    send(32'h12345678, 1'b1, 3'd4);
    beat("bp.b0", 8'h12, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
    beat("bp.hold0", 8'h34, 3'd1, 1'b0);
    beat("bp.hold1", 8'h34, 3'd1, 1'b0);
    beat("bp.hold2", 8'h34, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    beat("bp.b1", 8'h34, 3'd1, 1'b0);
    beat("bp.b2", 8'h56, 3'd2, 1'b0);
    beat("bp.b3", 8'h78, 3'd3, 1'b1);
    idle_chk("bp.end");

    // Back-to-back words with in_valid held
    bus.in_valid     = 1'b1;
    bus.in_data      = 32'hAABBCCDD;
    bus.in_msb_first = 1'b1;
    bus.in_len       = 3'd4;
    tick();
    bus.in_data = 32'h11223344;
    chk("b2b.aa.in_ready", 32'(bus.in_ready), 32'd0);
    beat("b2b.aa", 8'hAA, 3'd0, 1'b0);
    beat("b2b.bb", 8'hBB, 3'd1, 1'b0);
    beat("b2b.cc", 8'hCC, 3'd2, 1'b0);
    chk("b2b.dd.in_ready", 32'(bus.in_ready), 32'd1);
    beat("b2b.dd", 8'hDD, 3'd3, 1'b1);
    bus.in_valid = 1'b0;
    beat("b2b.11", 8'h11, 3'd0, 1'b0);
    beat("b2b.22", 8'h22, 3'd1, 1'b0);
    beat("b2b.33", 8'h33, 3'd2, 1'b0);
    beat("b2b.44", 8'h44, 3'd3, 1'b1);
    idle_chk("b2b.end");

    // Reset while out_idx=2
    send(32'h12345678, 1'b1, 3'd4);
    beat("mr.b0", 8'h12, 3'd0, 1'b0);
    beat("mr.b1", 8'h34, 3'd1, 1'b0);
    chk("mr.pre.idx", 32'(bus.out_idx), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr.data", 32'(bus.out_data), 32'd0);
    idle_chk("mr.post0");
    tick();
    idle_chk("mr.post1");
    tick();
    idle_chk("mr.post2");

    // Recovery after reset: LSB-first, len=3
    send(32'hCAFEF00D, 1'b0, 3'd3);
    beat("rec.b0", 8'h0D, 3'd0, 1'b0);
    beat("rec.b1", 8'hF0, 3'd1, 1'b0);
    beat("rec.b2", 8'hFE, 3'd2, 1'b1);
    idle_chk("rec.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
